keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad: drives one row low at a time, reads the four column lines back through a synchronizer, debounces, and emits one `keyValid` pulse with the key position for each debounced press. It is the input-side counterpart to the time-multiplexed display output path. It feeds the key-to-hex decode and display-register logic, which consume `keyCode`/`keyValid` in the `clk` domain.

---
 rtl/keypad_scanner.sv | 235 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one row at a time. The column lines
// pass through a two-flop synchronizer, and each press is debounced. One
// keyValid pulse carrying {row, col} is emitted per debounced press.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   When defined, a held key emits further keyValid pulses. The first comes
//   REPEAT_DELAY cycles after the initial pulse, and later ones come every
//   REPEAT_PERIOD cycles. When undefined, no repeat logic is built.
//
// Parameters
//   SCAN_DIV        clk cycles each row is driven before its columns are sampled (>= 3)
//   DEBOUNCE_CYCLES stable cycles required for both press and release (>= 1)
//   REPEAT_DELAY    HELD cycles before the first repeat pulse (autorepeat only)
//   REPEAT_PERIOD   cycles between later repeat pulses (autorepeat only)
//
// Ports
//   clk       in   system clock, the only clock
//   reset     in   synchronous, active-high reset
//   colIn     in   [3:0] keypad columns, active-low, asynchronous
//   rowOut    out  [3:0] keypad rows, active-low, one-hot-low
//   keyCode   out  [3:0] {rowIdx, colIdx} of the last accepted key
//   keyValid  out  one-cycle pulse; keyCode is valid in the same cycle
//   keyHeld   out  high while a debounced key is held
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV        = 24000,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int REPEAT_DELAY    = 12000000,
    parameter int REPEAT_PERIOD   = 2400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] colIn,
    output logic [3:0] rowOut,
    output logic [3:0] keyCode,
    output logic       keyValid,
    output logic       keyHeld
);
    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       col_meta_q, col_sync_q;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;       // press count in DEBOUNCE, release run in HELD
    logic [3:0]       row_out_q;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q;
    logic             rpt_fire_s;

    // Lowest-index low column; only meaningful when at least one column is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] cols);
        logic [1:0] idx;
        if (!cols[0]) begin
            idx = 2'd0;
        end else if (!cols[1]) begin
            idx = 2'd1;
        end else if (!cols[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Active-low one-hot row drive pattern for a row index.
    function automatic logic [3:0] row_drive(input logic [1:0] r);
        logic [3:0] pat;
        case (r)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            2'd3:    pat = 4'b0111;
            default: pat = 4'b1110;
        endcase
        return pat;
    endfunction

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;   // 1 = waiting out the initial delay

    // Repeat timer: runs only while the held column stays low in HELD.
    always_comb begin
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire_s  = 1'b0;
        if ((state_q != ST_HELD) || col_sync_q[col_q]) begin
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end else if ((rpt_first_q && (rpt_q == RPT_W'(REPEAT_DELAY - 1))) ||
                     (!rpt_first_q && (rpt_q == RPT_W'(REPEAT_PERIOD - 1)))) begin
            rpt_fire_s  = 1'b1;
            rpt_d       = '0;
            rpt_first_d = 1'b0;
        end else begin
            rpt_d = rpt_q + RPT_W'(1);
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    // Two-flop column synchronizer; idle (all released) value is all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= colIn;
            col_sync_q <= col_meta_q;
        end
    end

    // Next-state and datapath logic for the scan/debounce/held FSM.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (col_sync_q != 4'hF) begin
                        col_d   = lowest_low(col_sync_q);
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;    // 2-bit wrap gives 3 -> 0
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (col_sync_q[col_q]) begin
                    state_d = ST_SCAN;
                    div_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    key_code_d  = {row_q, col_q};
                    key_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            ST_HELD: begin
                if (col_sync_q[col_q]) begin
                    if (cnt_q == DB_LAST) begin
                        state_d = ST_SCAN;
                        row_d   = row_q + 2'd1;
                        div_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end else begin
                    cnt_d       = '0;
                    key_valid_d = rpt_fire_s;
                end
            end
            default: begin
                state_d = ST_SCAN;
                row_d   = 2'd0;
                div_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            div_q       <= '0;
            cnt_q       <= '0;
            row_out_q   <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            row_out_q   <= row_drive(row_d);
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= (state_d == ST_HELD);
        end
    end

    assign rowOut   = row_out_q;
    assign keyCode  = key_code_q;
    assign keyValid = key_valid_q;
    assign keyHeld  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 8;
    localparam int RD = 20;
    localparam int RP = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] colIn;
    logic [3:0] rowOut;
    logic [3:0] keyCode;
    logic       keyValid;
    logic       keyHeld;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .colIn(colIn), .rowOut(rowOut),
        .keyCode(keyCode), .keyValid(keyValid), .keyHeld(keyHeld)
    );

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    // Physical switch matrix: bit r*4+c closed means key (r,c) pressed.
    logic [15:0] keys = 16'h0;

    // Reference model, expressed as the behaviour of the keypad scanner.
    logic [3:0] hist[$];           // colIn samples still in flight through the synchronizer
    int         m_mode = 0;        // 0 scanning, 1 confirming press, 2 key held
    int         m_row = 0;
    int         m_col = 0;
    int         m_dwell = 0;       // cycles already spent on the current row
    int         m_run = 0;         // consecutive low (confirming) or high (held) cycles
    int         m_since = 0;       // cycles since last pulse while held low
    bit         m_first = 1'b1;
    logic [3:0] m_code = 4'h0;
    bit         m_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [3:0] s;
        s = hist[0];
        void'(hist.pop_front());
        hist.push_back(colIn);
        m_pulse = 1'b0;
        if (reset) begin
            hist    = '{4'hF, 4'hF};
            m_mode  = 0;
            m_row   = 0;
            m_dwell = 0;
            m_run   = 0;
            m_code  = 4'h0;
            return;
        end
        case (m_mode)
            0: begin
                if (m_dwell == SD - 1) begin
                    m_dwell = 0;
                    if (s != 4'hF) begin
                        for (int k = 3; k >= 0; k--) if (!s[k]) m_col = k;
                        m_mode = 1;
                        m_run  = 0;
                    end else begin
                        m_row = (m_row + 1) % 4;
                    end
                end else begin
                    m_dwell++;
                end
            end
            1: begin
                if (s[m_col]) begin
                    m_mode  = 0;
                    m_dwell = 0;
                end else begin
                    m_run++;
                    if (m_run == DB) begin
                        m_mode  = 2;
                        m_code  = 4'(m_row * 4 + m_col);
                        m_pulse = 1'b1;
                        m_run   = 0;
                        m_since = 0;
                        m_first = 1'b1;
                    end
                end
            end
            default: begin
                if (s[m_col]) begin
                    m_run++;
                    m_since = 0;
                    m_first = 1'b1;
                    if (m_run == DB) begin
                        m_mode  = 0;
                        m_row   = (m_row + 1) % 4;
                        m_dwell = 0;
                    end
                end else begin
                    m_run = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    m_since++;
                    if (m_since == (m_first ? RD : RP)) begin
                        m_pulse = 1'b1;
                        m_since = 0;
                        m_first = 1'b0;
                    end
`endif
                end
            end
        endcase
    endtask

    // One clock: present the keypad's column response, clock, then compare.
    task automatic tick();
        logic [3:0] c;
        logic [3:0] exp_row;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (rowOut[r] === 1'b0 && keys[r*4+k]) c[k] = 1'b0;
        colIn = c;
        @(posedge clk);
        model_step();
        #1;
        exp_row = 4'hF;
        exp_row[m_row] = 1'b0;
        check("rowOut", rowOut, exp_row);
        check("keyValid", keyValid, m_pulse);
        check("keyCode", keyCode, m_code);
        check("keyHeld", keyHeld, (m_mode == 2));
        if (keyValid === 1'b1) pulses++;
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (keyValid !== 1'b1 && n < budget);
        check(tag, keyValid, 1'b1);
    endtask

    task automatic wait_confirming(input int budget);
        int n;
        n = 0;
        while (m_mode != 1 && n < budget) begin
            tick();
            n++;
        end
        check("reach_debounce", m_mode, 1);
    endtask

    initial begin
        int         rpt_at[$];
        int         exp_rpt[$];
        logic [3:0] exp_r;
        logic [15:0] sel;

        hist  = '{4'hF, 4'hF};
        colIn = 4'hF;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state and idle row rotation
        check("rst_rowOut", rowOut, 4'b1110);
        check("rst_keyValid", keyValid, 1'b0);
        check("rst_keyCode", keyCode, 4'h0);
        check("rst_keyHeld", keyHeld, 1'b0);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_r = 4'hF;
            exp_r[(i / 4) % 4] = 1'b0;
            check("scan_seq", rowOut, exp_r);
        end
        check("idle_no_pulse", pulses, 0);

        // 2: stable press of key (1,2)
        pulses = 0;
        keys = 16'h0;
        keys[1*4+2] = 1'b1;
        wait_pulse("press_pulse", 200);
        check("press_code", keyCode, 4'b0110);
        check("press_held", keyHeld, 1'b1);
        repeat (10) tick();
        check("press_one_pulse", pulses, 1);
        keys = 16'h0;
        repeat (9) tick();
        check("release_still_held", keyHeld, 1'b1);
        tick();
        check("release_dropped", keyHeld, 1'b0);
        check("release_next_row", rowOut, 4'b1011);

        // 3: bouncing press of the same key
        repeat (6) tick();
        pulses = 0;
        repeat (6) begin
            keys[1*4+2] = 1'b1;
            repeat (3) tick();
            keys[1*4+2] = 1'b0;
            tick();
        end
        check("bounce_no_pulse", pulses, 0);
        keys[1*4+2] = 1'b1;
        wait_pulse("bounce_pulse", 200);
        check("bounce_code", keyCode, 4'b0110);
        check("bounce_one_pulse", pulses, 1);
        keys = 16'h0;
        repeat (14) tick();

        // 4: two columns low on row 3, then a short release glitch
        pulses = 0;
        keys[3*4+1] = 1'b1;
        keys[3*4+3] = 1'b1;
        wait_pulse("multi_pulse", 200);
        check("multi_code", keyCode, 4'b1101);
        keys = 16'h0;
        repeat (5) tick();
        keys[3*4+1] = 1'b1;
        keys[3*4+3] = 1'b1;
        repeat (12) tick();
        check("glitch_held", keyHeld, 1'b1);
        check("glitch_one_pulse", pulses, 1);
        keys = 16'h0;
        repeat (14) tick();
        check("multi_released", keyHeld, 1'b0);

        // 5: reset 5 cycles into debounce, then on the edge a pulse would fire
        pulses = 0;
        keys[3*4+1] = 1'b1;
        wait_confirming(100);
        repeat (5) tick();
        reset = 1'b1;
        keys = 16'h0;
        tick();
        check("rst_mid_rowOut", rowOut, 4'b1110);
        check("rst_mid_keyHeld", keyHeld, 1'b0);
        check("rst_mid_keyCode", keyCode, 4'h0);
        check("rst_mid_keyValid", keyValid, 1'b0);
        reset = 1'b0;
        keys[2*4+0] = 1'b1;
        wait_confirming(100);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check("rst_suppress_valid", keyValid, 1'b0);
        reset = 1'b0;
        keys = 16'h0;
        repeat (4) tick();
        check("rst_no_pulse", pulses, 0);

        // 6: long hold, repeat behaviour
        keys[1*4+1] = 1'b1;
        wait_pulse("hold_pulse", 200);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (keyValid === 1'b1) rpt_at.push_back(k);
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_rpt = '{20, 30, 40, 50, 60};
`endif
        check("rpt_count", rpt_at.size(), exp_rpt.size());
        for (int i = 0; i < exp_rpt.size() && i < rpt_at.size(); i++)
            check("rpt_time", rpt_at[i], exp_rpt[i]);
        check("rpt_code", keyCode, 4'b0101);
        keys = 16'h0;
        repeat (14) tick();

        // 7: randomized presses, bounces, releases and resets against the model
        for (int ep = 0; ep < 40; ep++) begin
            sel = 16'h0;
            sel[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 2) == 0) sel[$urandom_range(0, 15)] = 1'b1;
            repeat ($urandom_range(0, 4)) begin
                keys = sel;
                repeat ($urandom_range(1, 4)) tick();
                keys = 16'h0;
                repeat ($urandom_range(1, 2)) tick();
            end
            keys = sel;
            repeat ($urandom_range(0, 70)) tick();
            keys = 16'h0;
            repeat ($urandom_range(0, 30)) tick();
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
